// File: rtl/inst_fetch_buffer_pkg.sv
// spu_fetch_pkg: shared widths, NOP encoding and FIFO entry type for the SPU fetch buffer
package spu_fetch_pkg;
  localparam int INST_W = 32;
  localparam int PC_W = 18;
  localparam int INST_PAIR_W = 2 * INST_W;
  localparam logic [INST_W-1:0] NOP_INST = 32'h4020_0000;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_PAIR_W-1:0] pair;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_buffer_if.sv
// inst_fetch_buffer_if: LS read port, branch redirect and Decoder handshake of the fetch buffer
interface inst_fetch_buffer_if;
  import spu_fetch_pkg::*;
  logic lsRdEn;
  logic [PC_W-1:0] lsRdAddr;
  logic [INST_PAIR_W-1:0] lsRdData;
  logic redirectVal;
  logic [PC_W-1:0] redirectPc;
  logic stallIn;
  logic instValid;
  logic [INST_PAIR_W-1:0] instOut;
  logic [PC_W-1:0] pcOut;
  modport master (
    output lsRdEn, lsRdAddr, instValid, instOut, pcOut,
    input lsRdData, redirectVal, redirectPc, stallIn
  );
  modport slave (
    input lsRdEn, lsRdAddr, instValid, instOut, pcOut,
    output lsRdData, redirectVal, redirectPc, stallIn
  );
endinterface

// File: rtl/inst_fetch_buffer_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch entries; clear wins over push and pop
module fetch_fifo
  import spu_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= din_i;
      wr_q <= push_i ? wr_q + 1'b1 : wr_q;
      rd_q <= pop_i ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: fetches LS instruction pairs into a FIFO feeding the dual-issue Decoder.
// Define FETCH_PERF_EN to add the stall/empty/redirect performance counters.
module inst_fetch_buffer
  import spu_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  inst_fetch_buffer_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perfStallCnt,
  output logic [31:0] perfEmptyCnt,
  output logic [15:0] perfRedirCnt
`endif
);
  logic [PC_W-1:0] fetch_pc_q, resp_pc_q;
  logic run_q, inflight_q, kill_q, odd_q;
  logic issue, push, pop;
  logic [AW:0] count;
  logic [AW+1:0] used;
  logic unused_pc_bits;
  fetch_entry_t din, head;
  assign used = {1'b0, count} + {{(AW+1){1'b0}}, inflight_q};
  // run_q keeps the strobe low until the first edge after reset release
  assign issue = run_q && !bus.redirectVal && (used < (AW+2)'(DEPTH));
  assign push = inflight_q && !kill_q;
  assign pop = bus.instValid && !bus.stallIn;
  assign unused_pc_bits = ^bus.redirectPc[1:0];
  always_comb begin
    din.pc = resp_pc_q;
    din.pair = odd_q ? {NOP_INST, bus.lsRdData[INST_W-1:0]} : bus.lsRdData;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc_q <= '0;
      resp_pc_q <= '0;
      run_q <= 1'b0;
      inflight_q <= 1'b0;
      kill_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      inflight_q <= issue;
      kill_q <= bus.redirectVal && inflight_q;
      resp_pc_q <= fetch_pc_q;
      fetch_pc_q <= bus.redirectVal ? {bus.redirectPc[PC_W-1:3], 3'b000}
                  : issue ? fetch_pc_q + PC_W'(8) : fetch_pc_q;
      // odd-word target: only the first pair after the redirect gets slot 0 replaced
      odd_q <= bus.redirectVal ? bus.redirectPc[2] : push ? 1'b0 : odd_q;
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push_i(push),
    .pop_i(pop),
    .clear_i(bus.redirectVal),
    .din_i(din),
    .head_o(head),
    .count_o(count)
  );
  assign bus.lsRdEn = issue;
  assign bus.lsRdAddr = fetch_pc_q;
  assign bus.instValid = count != '0;
  assign bus.instOut = head.pair;
  assign bus.pcOut = head.pc;
`ifdef FETCH_PERF_EN
  logic redir_d_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      redir_d_q <= 1'b0;
      perfStallCnt <= '0;
      perfEmptyCnt <= '0;
      perfRedirCnt <= '0;
    end else begin
      redir_d_q <= bus.redirectVal;
      perfStallCnt <= (bus.instValid && bus.stallIn && !(&perfStallCnt)) ? perfStallCnt + 32'd1 : perfStallCnt;
      perfEmptyCnt <= (!bus.instValid && !redir_d_q && !(&perfEmptyCnt)) ? perfEmptyCnt + 32'd1 : perfEmptyCnt;
      perfRedirCnt <= (bus.redirectVal && !(&perfRedirCnt)) ? perfRedirCnt + 16'd1 : perfRedirCnt;
    end
`endif
endmodule
